alu: RTL and testbench
======================

Name: alu

Overview:
- 16-bit registered ALU for the processor datapath.
- Combines the A and B operand buses under a 3-bit opcode to drive the C result bus.
- Maintains a zero flag FLAG_Z that the control unit uses for conditional branching.
- Result and flag are registered: one clock of latency from operand/opcode to output.

Parameters:
- WIDTH, 16, data width of A_bus, B_bus and C_bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A_bus  input  WIDTH  operand A.
- B_bus  input  WIDTH  operand B.
- ALU_OP  input  3  operation select.
- C_bus  output  WIDTH  registered result.
- FLAG_Z  output  1  registered zero flag.

Behaviour:
- Reset:
  - rst_n low immediately forces C_bus=0 and FLAG_Z=0, independent of clk.
  - Both outputs hold at 0 while rst_n is low.
  - Release is sampled normally; the first update happens at the first rising edge with rst_n high.
  - Reset asserted mid-operation discards any pending update.
- Timing:
  - Inputs are sampled at each rising clk edge.
  - Outputs change only at that edge and reflect the inputs sampled there (latency 1 cycle).
  - No handshake; an operation is performed every cycle.
- Opcodes (all arithmetic modulo 2^WIDTH, unsigned, no carry/overflow output):
  - 0 ADD: C <= A+B, wraps on overflow; FLAG_Z <= 0.
  - 1 SUB: C <= A-B, wraps on borrow (e.g. 0-1 = all ones); FLAG_Z <= 1 if A==0, else 0. The flag tests operand A, not the result.
  - 2 PASS: C <= B. If A==0, FLAG_Z <= 1; otherwise FLAG_Z holds its previous value (sticky set, never cleared by PASS).
  - 3 ZER: C <= 0; FLAG_Z <= 0.
  - 5 MUL4: C <= A<<2, logical shift; the top two bits are discarded, zeros enter at the LSBs. FLAG_Z <= 0.
  - 6 DIV2: C <= A>>1, logical shift; zero enters at the MSB, the LSB is discarded. FLAG_Z <= 0.
  - 4 and 7 (unassigned): C_bus and FLAG_Z both hold their previous values (no-op).
- Unknown/X on ALU_OP is treated like an unassigned opcode: hold.
- B_bus is ignored by ZER, MUL4 and DIV2; A_bus affects PASS only through FLAG_Z.

Test Plan:
- Reset, then A=0x08F5, B=0x0485, one edge per op in sequence 0,1,2,3,5,6 -> C_bus = 0x0D7A, 0x0470, 0x0485, 0x0000, 0x23D4, 0x047A. FLAG_Z = 0 throughout (A nonzero; PASS holds the 0 left by SUB).
- SUB with A=0x0000, B=0x0001 -> C_bus=0xFFFF, FLAG_Z=1. Then PASS with A=0x0005, B=0x1234 -> C_bus=0x1234, FLAG_Z stays 1. Then ADD A=5, B=3 -> C_bus=0x0008, FLAG_Z=0.
- PASS with A=0x0000, B=0xABCD after FLAG_Z=0 -> C_bus=0xABCD, FLAG_Z=1.
- Wrap/shift edges:
  - ADD 0xFFFF+0x0002 -> 0x0001.
  - MUL4 A=0xC001 -> 0x0004.
  - DIV2 A=0x8001 -> 0x4000.
- Opcode 4 then 7 after ADD 0x0001+0x0001 (C=0x0002, Z=0) -> C_bus stays 0x0002 and FLAG_Z stays 0 for both cycles, with A/B changed to arbitrary values.
- Async reset:
  - Assert rst_n low between edges while C_bus=0x0D7A and FLAG_Z=1 -> both go to 0 immediately, without waiting for a clk edge.
  - Hold low across two edges with ADD applied -> outputs stay 0.
  - Release -> the next edge loads the ADD result.

Source files
------------

// File: rtl/alu.sv
// 16-bit registered ALU: combines A_bus and B_bus under ALU_OP into C_bus with one cycle of latency,
// and keeps a zero flag FLAG_Z for conditional branching.
module alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A_bus,
    input  logic [WIDTH-1:0] B_bus,
    input  logic [2:0]       ALU_OP,
    output logic [WIDTH-1:0] C_bus,
    output logic             FLAG_Z
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_PASS = 3'd2;
    localparam logic [2:0] OP_ZER  = 3'd3;
    localparam logic [2:0] OP_MUL4 = 3'd5;
    localparam logic [2:0] OP_DIV2 = 3'd6;

    logic [WIDTH-1:0] c_q, c_d;
    logic             z_q, z_d;
    logic             a_zero;

    assign a_zero = (A_bus == '0);

    // Opcodes 4, 7 and any unknown value fall to the default and hold both outputs.
    always_comb begin
        c_d = c_q;
        z_d = z_q;
        case (ALU_OP)
            OP_ADD: begin
                c_d = A_bus + B_bus;
                z_d = 1'b0;
            end
            OP_SUB: begin
                c_d = A_bus - B_bus;
                z_d = a_zero;
            end
            OP_PASS: begin
                c_d = B_bus;
                // Sticky: PASS can set the flag but never clears it.
                if (a_zero) begin
                    z_d = 1'b1;
                end
            end
            OP_ZER: begin
                c_d = '0;
                z_d = 1'b0;
            end
            OP_MUL4: begin
                c_d = {A_bus[WIDTH-3:0], 2'b00};
                z_d = 1'b0;
            end
            OP_DIV2: begin
                c_d = {1'b0, A_bus[WIDTH-1:1]};
                z_d = 1'b0;
            end
            default: begin
                c_d = c_q;
                z_d = z_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end

    assign C_bus  = c_q;
    assign FLAG_Z = z_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan cases plus randomized operations checked against
// an arithmetic reference model.
module tb_alu;

    localparam int WIDTH = 16;
    localparam int MODULUS = 65536;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] A_bus;
    logic [WIDTH-1:0] B_bus;
    logic [2:0]       ALU_OP;
    logic [WIDTH-1:0] C_bus;
    logic             FLAG_Z;

    int checks = 0;
    int errors = 0;

    // Reference state
    int mc = 0;
    int mz = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A_bus  (A_bus),
        .B_bus  (B_bus),
        .ALU_OP (ALU_OP),
        .C_bus  (C_bus),
        .FLAG_Z (FLAG_Z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain unsigned arithmetic modulo 2^WIDTH.
    task automatic model(input logic [2:0] op, input int a, input int b);
        if (op === 3'd0) begin
            mc = (a + b) % MODULUS;
            mz = 0;
        end else if (op === 3'd1) begin
            mc = (a - b + MODULUS) % MODULUS;
            mz = (a == 0) ? 1 : 0;
        end else if (op === 3'd2) begin
            mc = b;
            if (a == 0) mz = 1;
        end else if (op === 3'd3) begin
            mc = 0;
            mz = 0;
        end else if (op === 3'd5) begin
            mc = (a * 4) % MODULUS;
            mz = 0;
        end else if (op === 3'd6) begin
            mc = a / 2;
            mz = 0;
        end
    endtask

    // Drive one operation, clock it in, then compare against the model.
    task automatic step(input string tag, input logic [2:0] op, input int a, input int b);
        ALU_OP = op;
        A_bus  = a[WIDTH-1:0];
        B_bus  = b[WIDTH-1:0];
        @(posedge clk);
        #1;
        model(op, a, b);
        check({tag, "_c"}, 32'(C_bus), 32'(mc));
        check({tag, "_z"}, 32'(FLAG_Z), 32'(mz));
    endtask

    initial begin
        rst_n  = 1'b0;
        A_bus  = '0;
        B_bus  = '0;
        ALU_OP = 3'd0;
        #3;
        check("reset_c", 32'(C_bus), 32'h0);
        check("reset_z", 32'(FLAG_Z), 32'h0);
        #4;
        rst_n = 1'b1;

        // Operation sweep with fixed operands
        step("add", 3'd0, 16'h08F5, 16'h0485);
        check("plan_add", 32'(C_bus), 32'h0D7A);
        step("sub", 3'd1, 16'h08F5, 16'h0485);
        check("plan_sub", 32'(C_bus), 32'h0470);
        step("pass", 3'd2, 16'h08F5, 16'h0485);
        check("plan_pass", 32'(C_bus), 32'h0485);
        check("plan_pass_z", 32'(FLAG_Z), 32'h0);
        step("zer", 3'd3, 16'h08F5, 16'h0485);
        check("plan_zer", 32'(C_bus), 32'h0000);
        step("mul4", 3'd5, 16'h08F5, 16'h0485);
        check("plan_mul4", 32'(C_bus), 32'h23D4);
        step("div2", 3'd6, 16'h08F5, 16'h0485);
        check("plan_div2", 32'(C_bus), 32'h047A);

        // Flag behaviour
        step("sub0", 3'd1, 16'h0000, 16'h0001);
        check("plan_sub0", 32'(C_bus), 32'hFFFF);
        check("plan_sub0_z", 32'(FLAG_Z), 32'h1);
        step("pass_hold", 3'd2, 16'h0005, 16'h1234);
        check("plan_pass_sticky", 32'(FLAG_Z), 32'h1);
        step("add_clr", 3'd0, 5, 3);
        check("plan_add_clr", 32'(C_bus), 32'h0008);
        check("plan_add_clr_z", 32'(FLAG_Z), 32'h0);
        step("pass_set", 3'd2, 16'h0000, 16'hABCD);
        check("plan_pass_set", 32'(FLAG_Z), 32'h1);

        // Wrap and shift edges
        step("add_wrap", 3'd0, 16'hFFFF, 16'h0002);
        check("plan_add_wrap", 32'(C_bus), 32'h0001);
        step("mul4_edge", 3'd5, 16'hC001, 16'h5555);
        check("plan_mul4_edge", 32'(C_bus), 32'h0004);
        step("div2_edge", 3'd6, 16'h8001, 16'hAAAA);
        check("plan_div2_edge", 32'(C_bus), 32'h4000);

        // Unassigned and unknown opcodes hold
        step("add11", 3'd0, 1, 1);
        step("op4", 3'd4, 16'h1357, 16'h0000);
        check("plan_op4", 32'(C_bus), 32'h0002);
        step("op7", 3'd7, 16'h0000, 16'hFFFF);
        check("plan_op7", 32'(C_bus), 32'h0002);
        check("plan_op7_z", 32'(FLAG_Z), 32'h0);
        step("opx", 3'bxxx, 16'h0000, 16'h7777);

        // Randomized operations; A is biased toward zero to exercise the flag paths
        for (int i = 0; i < 400; i++) begin
            int a;
            int b;
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535));
            b = ($urandom_range(0, 7) == 0) ? 65535 : int'($urandom_range(0, 65535));
            step("rand", op, a, b);
        end

        // Asynchronous reset between edges
        step("pre_rst", 3'd2, 16'h0000, 16'h0D7A);
        check("plan_pre_rst_c", 32'(C_bus), 32'h0D7A);
        check("plan_pre_rst_z", 32'(FLAG_Z), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        mc = 0;
        mz = 0;
        check("async_rst_c", 32'(C_bus), 32'h0);
        check("async_rst_z", 32'(FLAG_Z), 32'h0);
        ALU_OP = 3'd0;
        A_bus  = 16'h0010;
        B_bus  = 16'h0020;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_c", 32'(C_bus), 32'h0);
            check("rst_hold_z", 32'(FLAG_Z), 32'h0);
        end
        rst_n = 1'b1;
        step("post_rst", 3'd0, 16'h0010, 16'h0020);
        check("plan_post_rst", 32'(C_bus), 32'h0030);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
